rs_alu_cluster: RTL and testbench
=================================

RS_ALU_CLUSTER -- requirements
Module: rs_alu_cluster

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand/result width in bits.
REQ-002 The block SHALL have parameter TAGW, default 4, producer-tag width; tag 0 means "value present".
REQ-003 The block SHALL have parameter ENTRIES, default 4, reservation-station depth; legal range 2..8.
REQ-004 The block SHALL have parameter UNIT_BASE, default 1, tag of entry 0; entry i owns tag UNIT_BASE+i; UNIT_BASE>=1 and UNIT_BASE+ENTRIES-1 < 2**TAGW.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- CLOCK_50  in  1  clock, rising edge
- RSTN_N  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous discard of all state
- issue_valid_i  in  1  dispatcher offers an instruction
- issue_ready_o  out  1  at least one entry FREE
- issue_op_i  in  2  00 ADD, 01 SUB, 10 SLT, 11 SLTU
- issue_tag1_i, issue_tag2_i  in  TAGW  operand producer tags
- issue_val1_i, issue_val2_i  in  XLEN  operand values, used when tag is 0
- issue_tag_o  out  TAGW  tag allocated to the offered instruction (dispatcher renames rd to it)
- cdb_in_valid_i  in  1  global broadcast valid
- cdb_in_tag_i  in  TAGW  global broadcast tag
- cdb_in_data_i  in  XLEN  global broadcast data
- cdb_valid_o  out  1  result request to the CDB arbiter
- cdb_ready_i  in  1  arbiter grant
- cdb_tag_o  out  TAGW  result tag
- cdb_data_o  out  XLEN  result
- busy_count_o  out  $clog2(ENTRIES+1)  number of non-FREE entries

Function
REQ-006 Each entry SHALL hold state FREE, WAIT, READY or EXEC, plus op, tag1/val1 and tag2/val2.
REQ-007 issue_ready_o SHALL be high iff any entry is FREE; issue_tag_o SHALL be UNIT_BASE plus the lowest FREE index, combinational from registered state.
REQ-008 On issue_valid_i & issue_ready_o at an edge, the lowest FREE entry SHALL load op/tags/values and go to READY if both captured tags are 0, else WAIT.
REQ-009 If an issue operand tag equals cdb_in_tag_i while cdb_in_valid_i is high in the same cycle, that operand SHALL be captured as cdb_in_data_i with tag 0.
REQ-010 On cdb_in_valid_i, every WAIT entry operand whose nonzero tag matches cdb_in_tag_i SHALL capture cdb_in_data_i and clear its tag; the entry goes to READY when both tags are 0.
REQ-011 The CDB input SHALL be ignored when cdb_in_tag_i is 0.
REQ-012 An output register (valid, tag, data) SHALL be loaded from the lowest-index READY entry when it is empty or is being drained (cdb_valid_o & cdb_ready_i) in that cycle; that entry goes to EXEC.
REQ-013 Arithmetic: ADD/SUB SHALL be modulo 2**XLEN; SLT SHALL be a signed compare and SLTU unsigned, each giving 1 or 0 zero-extended to XLEN.
REQ-014 cdb_valid_o/cdb_tag_o/cdb_data_o SHALL hold stable while cdb_valid_o & !cdb_ready_i.
REQ-015 On cdb_valid_o & cdb_ready_i, the EXEC entry with tag cdb_tag_o SHALL become FREE at that edge; it is not re-allocatable in the same cycle.
REQ-016 Minimum latency SHALL be: issue accepted at edge k with ready operands -> cdb_valid_o high after edge k+1.
REQ-017 Own results SHALL wake own entries only via the cdb_in_* inputs, not internally.
REQ-018 busy_count_o SHALL equal the registered count of non-FREE entries, saturating at neither end (exact by construction).
REQ-019 flush_i SHALL take priority over issue, wakeup and drain: all entries go FREE and the output register is cleared at that edge.
REQ-020 When all entries are occupied, issue_valid_i SHALL be ignored and no state is modified by it.

Reset
REQ-021 While RSTN_N is low, all entries SHALL be FREE, all stored tags/values/op 0, the output register invalid, cdb_tag_o 0, cdb_data_o 0, busy_count_o 0, issue_ready_o 1 and issue_tag_o UNIT_BASE.
REQ-022 Reset asserted mid-operation SHALL discard in-flight entries and a pending CDB result without producing a handshake.

Verification
REQ-023 ADD, tags 0, values 5 and 7, cdb_ready_i=1 -> cdb_valid_o after edge k+1, tag 1, data 12; entry FREE the next cycle.
REQ-024 SUB 3-5 -> data 0xFFFFFFFE; SLT with 0xFFFFFFFF and 1 -> 1; SLTU with the same values -> 0.
REQ-025 Issue ADD with tag1=6 and val2=10; cdb_in tag 6 data 4 two cycles later -> result 14 one edge after wakeup; with tag6 broadcast in the same cycle as issue -> bypassed capture.
REQ-026 Fill 4 entries -> issue_ready_o=0 and busy_count_o=4; an extra issue is ignored; hold cdb_ready_i=0 for 3 cycles -> outputs stable; grant -> busy_count_o=3.
REQ-027 Two READY entries (indices 0 and 2) -> index 0 (tag 1) is broadcast first, then tag 3, back-to-back with cdb_ready_i=1.
REQ-028 Assert flush_i or RSTN_N low with 3 entries busy and a pending result -> busy_count_o=0 and cdb_valid_o=0 the next cycle.

Source files
------------

// File: rtl/rs_alu_cluster.sv
// Reservation-station ALU cluster: tag-tracked operand capture, CDB wakeup,
// oldest-index-first dispatch into a single registered CDB result slot.
module rs_alu_cluster #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned TAGW      = 4,
    parameter int unsigned ENTRIES   = 4,
    parameter int unsigned UNIT_BASE = 1
) (
    input  logic                             CLOCK_50,
    input  logic                             RSTN_N,
    input  logic                             flush_i,
    input  logic                             issue_valid_i,
    output logic                             issue_ready_o,
    input  logic [1:0]                       issue_op_i,
    input  logic [TAGW-1:0]                  issue_tag1_i,
    input  logic [TAGW-1:0]                  issue_tag2_i,
    input  logic [XLEN-1:0]                  issue_val1_i,
    input  logic [XLEN-1:0]                  issue_val2_i,
    output logic [TAGW-1:0]                  issue_tag_o,
    input  logic                             cdb_in_valid_i,
    input  logic [TAGW-1:0]                  cdb_in_tag_i,
    input  logic [XLEN-1:0]                  cdb_in_data_i,
    output logic                             cdb_valid_o,
    input  logic                             cdb_ready_i,
    output logic [TAGW-1:0]                  cdb_tag_o,
    output logic [XLEN-1:0]                  cdb_data_o,
    output logic [$clog2(ENTRIES+1)-1:0]     busy_count_o
);

    localparam int unsigned BCW  = $clog2(ENTRIES + 1);
    localparam int unsigned IDXW = $clog2(ENTRIES);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } ent_state_e;

    typedef struct packed {
        ent_state_e        state;
        logic [1:0]        op;
        logic [TAGW-1:0]   tag1;
        logic [XLEN-1:0]   val1;
        logic [TAGW-1:0]   tag2;
        logic [XLEN-1:0]   val2;
    } entry_t;

    localparam entry_t ENTRY_RST = '{state: ST_FREE, op: '0, tag1: '0,
                                     val1: '0, tag2: '0, val2: '0};

    entry_t             ent_q [ENTRIES];
    entry_t             ent_d [ENTRIES];
    logic               out_valid_q, out_valid_d;
    logic [TAGW-1:0]    out_tag_q,   out_tag_d;
    logic [XLEN-1:0]    out_data_q,  out_data_d;
    logic [BCW-1:0]     busy_q,      busy_d;

    logic               free_found;
    logic [IDXW-1:0]    free_idx;
    logic               ready_found;
    logic [IDXW-1:0]    ready_idx;

    function automatic logic [XLEN-1:0] alu(input logic [1:0] op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = XLEN'($signed(a) < $signed(b));
            default: r = XLEN'(a < b);
        endcase
        return r;
    endfunction

    // State register: entries, CDB output slot, busy counter
    always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
        if (!RSTN_N) begin
            for (int i = 0; i < int'(ENTRIES); i++) ent_q[i] <= ENTRY_RST;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_data_q  <= '0;
            busy_q      <= '0;
        end else begin
            for (int i = 0; i < int'(ENTRIES); i++) ent_q[i] <= ent_d[i];
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    // Lowest-index FREE and READY entry selection from registered state
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        ready_idx   = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (ent_q[i].state == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = IDXW'(i);
            end
            if (ent_q[i].state == ST_READY) begin
                ready_found = 1'b1;
                ready_idx   = IDXW'(i);
            end
        end
    end

    // Next-state: wakeup, drain, dispatch, issue, flush
    always_comb begin
        logic            drain;
        logic            load;
        logic            wake;
        logic [TAGW-1:0] cap_tag1, cap_tag2;
        logic [XLEN-1:0] cap_val1, cap_val2;
        int unsigned     cnt;

        for (int i = 0; i < int'(ENTRIES); i++) ent_d[i] = ent_q[i];
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;

        drain = out_valid_q & cdb_ready_i;
        load  = ready_found & (~out_valid_q | drain);
        wake  = cdb_in_valid_i && (cdb_in_tag_i != '0);

        // Issue-time operand capture with same-cycle broadcast bypass
        cap_tag1 = issue_tag1_i;
        cap_val1 = issue_val1_i;
        cap_tag2 = issue_tag2_i;
        cap_val2 = issue_val2_i;
        if (wake && issue_tag1_i == cdb_in_tag_i) begin
            cap_tag1 = '0;
            cap_val1 = cdb_in_data_i;
        end
        if (wake && issue_tag2_i == cdb_in_tag_i) begin
            cap_tag2 = '0;
            cap_val2 = cdb_in_data_i;
        end

        if (drain) out_valid_d = 1'b0;
        if (load) begin
            out_valid_d = 1'b1;
            out_tag_d   = TAGW'(UNIT_BASE) + TAGW'(ready_idx);
            out_data_d  = alu(ent_q[ready_idx].op, ent_q[ready_idx].val1,
                              ent_q[ready_idx].val2);
        end

        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (wake && ent_q[i].state == ST_WAIT) begin
                if (ent_q[i].tag1 == cdb_in_tag_i) begin
                    ent_d[i].tag1 = '0;
                    ent_d[i].val1 = cdb_in_data_i;
                end
                if (ent_q[i].tag2 == cdb_in_tag_i) begin
                    ent_d[i].tag2 = '0;
                    ent_d[i].val2 = cdb_in_data_i;
                end
                if (ent_d[i].tag1 == '0 && ent_d[i].tag2 == '0)
                    ent_d[i].state = ST_READY;
            end
            if (drain && ent_q[i].state == ST_EXEC &&
                out_tag_q == TAGW'(UNIT_BASE + i))
                ent_d[i].state = ST_FREE;
            if (load && ready_idx == IDXW'(i))
                ent_d[i].state = ST_EXEC;
            if (issue_valid_i && free_found && free_idx == IDXW'(i)) begin
                ent_d[i].op    = issue_op_i;
                ent_d[i].tag1  = cap_tag1;
                ent_d[i].val1  = cap_val1;
                ent_d[i].tag2  = cap_tag2;
                ent_d[i].val2  = cap_val2;
                ent_d[i].state = (cap_tag1 == '0 && cap_tag2 == '0) ? ST_READY : ST_WAIT;
            end
        end

        if (flush_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) ent_d[i] = ENTRY_RST;
            out_valid_d = 1'b0;
            out_tag_d   = '0;
            out_data_d  = '0;
        end

        cnt = 0;
        for (int i = 0; i < int'(ENTRIES); i++)
            if (ent_d[i].state != ST_FREE) cnt = cnt + 1;
        busy_d = BCW'(cnt);
    end

    // Outputs: allocation view from registered state, result slot registers
    always_comb begin
        issue_ready_o = free_found;
        issue_tag_o   = TAGW'(UNIT_BASE) + TAGW'(free_idx);
        cdb_valid_o   = out_valid_q;
        cdb_tag_o     = out_tag_q;
        cdb_data_o    = out_data_q;
        busy_count_o  = busy_q;
    end

endmodule

// File: tb/tb_rs_alu_cluster.sv
// Directed bench for rs_alu_cluster with hand-computed expected values.
module tb_rs_alu_cluster;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TAGW = 4;

    logic              CLOCK_50;
    logic              RSTN_N;
    logic              flush_i;
    logic              issue_valid_i;
    logic              issue_ready_o;
    logic [1:0]        issue_op_i;
    logic [TAGW-1:0]   issue_tag1_i, issue_tag2_i;
    logic [XLEN-1:0]   issue_val1_i, issue_val2_i;
    logic [TAGW-1:0]   issue_tag_o;
    logic              cdb_in_valid_i;
    logic [TAGW-1:0]   cdb_in_tag_i;
    logic [XLEN-1:0]   cdb_in_data_i;
    logic              cdb_valid_o;
    logic              cdb_ready_i;
    logic [TAGW-1:0]   cdb_tag_o;
    logic [XLEN-1:0]   cdb_data_o;
    logic [2:0]        busy_count_o;

    int n_vec;
    int n_err;

    rs_alu_cluster dut (
        .CLOCK_50       (CLOCK_50),
        .RSTN_N         (RSTN_N),
        .flush_i        (flush_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .issue_op_i     (issue_op_i),
        .issue_tag1_i   (issue_tag1_i),
        .issue_tag2_i   (issue_tag2_i),
        .issue_val1_i   (issue_val1_i),
        .issue_val2_i   (issue_val2_i),
        .issue_tag_o    (issue_tag_o),
        .cdb_in_valid_i (cdb_in_valid_i),
        .cdb_in_tag_i   (cdb_in_tag_i),
        .cdb_in_data_i  (cdb_in_data_i),
        .cdb_valid_o    (cdb_valid_o),
        .cdb_ready_i    (cdb_ready_i),
        .cdb_tag_o      (cdb_tag_o),
        .cdb_data_o     (cdb_data_o),
        .busy_count_o   (busy_count_o)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] t1, input logic [31:0] v1,
                         input logic [3:0] t2, input logic [31:0] v2);
        issue_valid_i = 1'b1;
        issue_op_i    = op;
        issue_tag1_i  = t1;
        issue_val1_i  = v1;
        issue_tag2_i  = t2;
        issue_val2_i  = v2;
    endtask

    task automatic no_issue();
        issue_valid_i = 1'b0;
        issue_op_i    = 2'b00;
        issue_tag1_i  = '0;
        issue_tag2_i  = '0;
        issue_val1_i  = '0;
        issue_val2_i  = '0;
    endtask

    task automatic bcast(input logic v, input logic [3:0] t, input logic [31:0] d);
        cdb_in_valid_i = v;
        cdb_in_tag_i   = t;
        cdb_in_data_i  = d;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] t, input logic [31:0] d);
        chk({tag, ".valid"}, 64'(cdb_valid_o), 64'(v));
        chk({tag, ".tag"},   64'(cdb_tag_o),   64'(t));
        chk({tag, ".data"},  64'(cdb_data_o),  64'(d));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RSTN_N = 1'b0;
        flush_i = 1'b0;
        cdb_ready_i = 1'b0;
        no_issue();
        bcast(1'b0, 4'd0, 32'd0);
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk_out("rst", 1'b0, 4'd0, 32'd0);
        chk("rst.busy",  64'(busy_count_o),  64'd0);
        chk("rst.ready", 64'(issue_ready_o), 64'd1);
        chk("rst.itag",  64'(issue_tag_o),   64'd1);
        RSTN_N = 1'b1;
        tick();

        // Single ADD, minimum latency, entry freed after grant
        cdb_ready_i = 1'b1;
        issue(2'b00, 4'd0, 32'd5, 4'd0, 32'd7);
        tick();
        no_issue();
        chk("add.busy1", 64'(busy_count_o), 64'd1);
        chk("add.itag1", 64'(issue_tag_o),  64'd2);
        chk("add.val_k", 64'(cdb_valid_o),  64'd0);
        tick();
        chk_out("add", 1'b1, 4'd1, 32'd12);
        tick();
        chk("add.drained", 64'(cdb_valid_o),  64'd0);
        chk("add.busy0",   64'(busy_count_o), 64'd0);
        chk("add.itag0",   64'(issue_tag_o),  64'd1);

        // SUB / SLT / SLTU pipelined back-to-back
        issue(2'b01, 4'd0, 32'd3, 4'd0, 32'd5);
        tick();
        issue(2'b10, 4'd0, 32'hFFFF_FFFF, 4'd0, 32'd1);
        tick();
        chk_out("sub", 1'b1, 4'd1, 32'hFFFF_FFFE);
        issue(2'b11, 4'd0, 32'hFFFF_FFFF, 4'd0, 32'd1);
        tick();
        no_issue();
        chk_out("slt", 1'b1, 4'd2, 32'd1);
        tick();
        chk_out("sltu", 1'b1, 4'd3, 32'd0);
        tick();
        chk("arith.idle", 64'(cdb_valid_o),  64'd0);
        chk("arith.busy", 64'(busy_count_o), 64'd0);

        // Wakeup of a waiting operand two cycles after issue
        issue(2'b00, 4'd6, 32'd0, 4'd0, 32'd10);
        tick();
        no_issue();
        chk("wake.busy", 64'(busy_count_o), 64'd1);
        tick();
        chk("wake.wait", 64'(cdb_valid_o), 64'd0);
        bcast(1'b1, 4'd6, 32'd4);
        tick();
        bcast(1'b0, 4'd0, 32'd0);
        chk("wake.notyet", 64'(cdb_valid_o), 64'd0);
        tick();
        chk_out("wake", 1'b1, 4'd1, 32'd14);
        tick();
        chk("wake.busy0", 64'(busy_count_o), 64'd0);

        // Broadcast in the issue cycle is bypassed into the new entry
        issue(2'b00, 4'd6, 32'd0, 4'd0, 32'd10);
        bcast(1'b1, 4'd6, 32'd4);
        tick();
        no_issue();
        bcast(1'b0, 4'd0, 32'd0);
        tick();
        chk_out("bypass", 1'b1, 4'd1, 32'd14);
        tick();

        // Broadcast with tag 0 must not disturb present operands
        issue(2'b00, 4'd0, 32'd5, 4'd0, 32'd7);
        bcast(1'b1, 4'd0, 32'd100);
        tick();
        no_issue();
        bcast(1'b0, 4'd0, 32'd0);
        tick();
        chk_out("tag0", 1'b1, 4'd1, 32'd12);
        tick();

        // Entries 0 and 2 become READY together; index order on the CDB
        issue(2'b00, 4'd8, 32'd0, 4'd0, 32'd10);
        tick();
        issue(2'b01, 4'd7, 32'd0, 4'd0, 32'd3);
        tick();
        issue(2'b00, 4'd0, 32'd100, 4'd8, 32'd0);
        tick();
        no_issue();
        chk("ord.busy3", 64'(busy_count_o), 64'd3);
        bcast(1'b1, 4'd8, 32'd5);
        tick();
        bcast(1'b0, 4'd0, 32'd0);
        chk("ord.idle", 64'(cdb_valid_o), 64'd0);
        tick();
        chk_out("ord.first", 1'b1, 4'd1, 32'd15);
        tick();
        chk_out("ord.second", 1'b1, 4'd3, 32'd105);
        tick();
        chk("ord.gap",   64'(cdb_valid_o),  64'd0);
        chk("ord.busy1", 64'(busy_count_o), 64'd1);
        bcast(1'b1, 4'd7, 32'd20);
        tick();
        bcast(1'b0, 4'd0, 32'd0);
        tick();
        chk_out("ord.third", 1'b1, 4'd2, 32'd17);
        tick();
        chk("ord.busy0", 64'(busy_count_o), 64'd0);

        // Fill all entries under back-pressure
        cdb_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            issue(2'b00, 4'd0, 32'(i), 4'd0, 32'(i));
            tick();
        end
        chk("full.ready", 64'(issue_ready_o), 64'd0);
        chk("full.busy",  64'(busy_count_o),  64'd4);
        issue(2'b00, 4'd0, 32'd9, 4'd0, 32'd9);
        tick();
        no_issue();
        chk("full.extra", 64'(busy_count_o), 64'd4);
        for (int i = 0; i < 3; i++) begin
            chk_out("stall", 1'b1, 4'd1, 32'd2);
            tick();
        end
        chk_out("stall.end", 1'b1, 4'd1, 32'd2);
        cdb_ready_i = 1'b1;
        tick();
        cdb_ready_i = 1'b0;
        chk("grant.busy",  64'(busy_count_o),  64'd3);
        chk_out("grant.next", 1'b1, 4'd2, 32'd4);
        chk("grant.ready", 64'(issue_ready_o), 64'd1);
        chk("grant.itag",  64'(issue_tag_o),   64'd1);

        // Flush with three busy entries and a pending result
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush.busy", 64'(busy_count_o), 64'd0);
        chk_out("flush", 1'b0, 4'd0, 32'd0);
        chk("flush.itag", 64'(issue_tag_o), 64'd1);

        // Asynchronous reset with three busy entries and a pending result
        for (int i = 1; i <= 3; i++) begin
            issue(2'b00, 4'd0, 32'(i), 4'd0, 32'(i));
            tick();
        end
        no_issue();
        chk("prerst.busy",  64'(busy_count_o), 64'd3);
        chk("prerst.valid", 64'(cdb_valid_o),  64'd1);
        RSTN_N = 1'b0;
        #1;
        chk("arst.busy",  64'(busy_count_o),  64'd0);
        chk("arst.valid", 64'(cdb_valid_o),   64'd0);
        chk("arst.ready", 64'(issue_ready_o), 64'd1);
        cdb_ready_i = 1'b1;
        tick();
        RSTN_N = 1'b1;
        tick();
        chk("postrst.valid", 64'(cdb_valid_o),  64'd0);
        chk("postrst.busy",  64'(busy_count_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
